voxel_projector: RTL

Parametrised orthographic voxel renderer. Holds an N×N×N 1-bit voxel grid, loaded through a side port, and redraws an N×N depth-shaded projection into framebuffer RAM once per frame. It sits beside the video sync generator and shares the framebuffer write port with the CPU side. It issues RAM writes only during blanking, scans one voxel per cycle, and supports four view axes.

---
 rtl/voxel_pkg.sv | 56 +++++
 rtl/voxel_if.sv | 31 +++
 rtl/voxel_store.sv | 29 ++
 rtl/voxel_projector.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/voxel_pkg.sv
// Shared definitions for the voxel projector.
//   state_t   : renderer FSM states (IDLE, SCAN, WRITE, DONE)
//   AXIS_*    : view-axis encodings carried on the 2-bit axis input
//   shade()   : saturating depth shading
//   map_coord : (axis, u, v, d) -> packed voxel index {z,y,x}
package voxel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] AXIS_XYZ  = 2'd0;  // u=x, v=y, d=z
    localparam logic [1:0] AXIS_XZY  = 2'd1;  // u=x, v=z, d=y
    localparam logic [1:0] AXIS_ZYX  = 2'd2;  // u=z, v=y, d=x
    localparam logic [1:0] AXIS_BACK = 2'd3;  // u=x, v=y, d=N-1-z

    // fg - d*step, clamped at zero. Evaluated at 32 bits, which is never
    // narrower than DATA_W+GRID_BITS for the supported sizes, so the
    // product cannot wrap before the comparison.
    function automatic logic [31:0] shade(input logic [31:0] fg,
                                          input logic [31:0] step,
                                          input logic [31:0] d);
        logic [31:0] drop;
        drop = step * d;
        return (drop > fg) ? 32'd0 : fg - drop;
    endfunction

    // Converts projection coordinates into the {z,y,x} voxel index for a
    // grid of side 2^gb. Fields are packed gb bits each, x in the LSBs.
    function automatic logic [31:0] map_coord(input logic [1:0]  axis,
                                              input logic [31:0] u,
                                              input logic [31:0] v,
                                              input logic [31:0] d,
                                              input int          gb);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] top;
        top = (32'd1 << gb) - 32'd1;
        x = u;
        y = v;
        z = d;
        case (axis)
            AXIS_XYZ:  ;
            AXIS_XZY:  begin x = u; z = v; y = d; end
            AXIS_ZYX:  begin z = u; y = v; x = d; end
            AXIS_BACK: z = top - d;
            default:   ;
        endcase
        return (z << (2 * gb)) | (y << gb) | x;
    endfunction

endpackage

// File: rtl/voxel_if.sv
// Framebuffer write bus plus voxel load side port of the projector.
//   we, addr, ram_d     : framebuffer write request (projector drives)
//   ram_ready           : arbiter accepts the write this cycle
//   vox_we/addr/d       : voxel grid load strobe, index {z,y,x}, value
// Handshake: we is the valid, ram_ready the ready. A write transfers on a
// cycle where we && ram_ready && !display_on. Once we is high, addr and
// ram_d hold their values and we stays high until that transfer happens;
// we drops the cycle after the transfer.
interface voxel_if #(
    parameter int GRID_BITS = 3,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8
);
    logic                   we;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      ram_d;
    logic                   ram_ready;
    logic                   vox_we;
    logic [3*GRID_BITS-1:0] vox_addr;
    logic                   vox_d;

    modport master (
        output we, addr, ram_d,
        input  ram_ready, vox_we, vox_addr, vox_d
    );

    modport slave (
        input  we, addr, ram_d,
        output ram_ready, vox_we, vox_addr, vox_d
    );
endinterface

// File: rtl/voxel_store.sv
// N^3 x 1-bit voxel array, N = 2^GRID_BITS.
//   clk, reset : clock, async active-high clear of every voxel
//   we/waddr/wd: single write port
//   raddr/rd   : combinational read port
module voxel_store #(
    parameter int GRID_BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [3*GRID_BITS-1:0] waddr,
    input  logic                   wd,
    input  logic [3*GRID_BITS-1:0] raddr,
    output logic                   rd
);
    localparam int DEPTH = 1 << (3 * GRID_BITS);

    logic [DEPTH-1:0] mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wd;
        end
    end

    assign rd = mem[raddr];
endmodule

// File: rtl/voxel_projector.sv
// Orthographic voxel renderer. On the frame trigger (hpos==0, vpos==
// START_LINE) it walks every projected cell (u,v), scans depth d from the
// front until it finds a set voxel or runs out of depth, and writes one
// depth-shaded pixel per cell into the framebuffer during blanking.
//   clk, reset         : pixel clock, async active-high reset
//   fb (voxel_if)      : framebuffer write bus and voxel load port
//   display_on         : active picture; framebuffer writes stall while high
//   hpos, vpos         : raster position, used only for the trigger
//   axis               : view select, latched at frame start
//   busy               : frame in progress (SCAN/WRITE/DONE)
//   done               : one-cycle pulse after the last write completes
//   overrun            : one-cycle pulse when a trigger lands while busy
//   dbg_state          : current FSM state
module voxel_projector
    import voxel_pkg::*;
#(
    parameter int                 GRID_BITS  = 3,
    parameter int                 ADDR_W     = 12,
    parameter int                 DATA_W     = 8,
    parameter int unsigned        FB_BASE    = 0,
    parameter int unsigned        FB_STRIDE  = 16,
    parameter int unsigned        START_LINE = 240,
    parameter logic [DATA_W-1:0]  FG_COLOR   = 8'hFF,
    parameter logic [DATA_W-1:0]  SHADE_STEP = 8'h10,
    parameter logic [DATA_W-1:0]  BG_COLOR   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    voxel_if.master    fb,
    input  logic       display_on,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic [1:0] axis,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output state_t     dbg_state
);
    localparam int CW = 3 * GRID_BITS;

    state_t                 state_q;
    logic [1:0]             axis_q;
    logic [GRID_BITS-1:0]   u_q;
    logic [GRID_BITS-1:0]   v_q;
    logic [GRID_BITS-1:0]   d_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      ram_d_q;

    logic                   trigger;
    logic                   store_we;
    logic                   vox_hit;
    logic [CW-1:0]          rd_addr;
    logic [ADDR_W-1:0]      cell_addr;
    logic [DATA_W-1:0]      hit_color;
    logic                   write_done;

    assign trigger    = (hpos == 9'd0) && (vpos == 9'(START_LINE));
    // Loads are only honoured while idle so a frame sees a stable grid.
    assign store_we   = fb.vox_we && (state_q == IDLE);
    assign rd_addr    = CW'(map_coord(axis_q, 32'(u_q), 32'(v_q), 32'(d_q), GRID_BITS));
    // Address arithmetic is done at 32 bits and truncated, so it wraps
    // modulo 2^ADDR_W.
    assign cell_addr  = ADDR_W'(FB_BASE + 32'(v_q) * FB_STRIDE + 32'(u_q));
    assign hit_color  = DATA_W'(shade(32'(FG_COLOR), 32'(SHADE_STEP), 32'(d_q)));
    // we_q is always high in WRITE; this is the transfer condition.
    assign write_done = fb.ram_ready && !display_on;

    voxel_store #(
        .GRID_BITS (GRID_BITS)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (store_we),
        .waddr (fb.vox_addr),
        .wd    (fb.vox_d),
        .raddr (rd_addr),
        .rd    (vox_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            axis_q  <= AXIS_XYZ;
            u_q     <= '0;
            v_q     <= '0;
            d_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ram_d_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= trigger && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q <= SCAN;
                        axis_q  <= axis;
                        u_q     <= '0;
                        v_q     <= '0;
                        d_q     <= '0;
                        busy    <= 1'b1;
                    end
                end
                SCAN: begin
                    // addr/ram_d are only loaded here, on entry to WRITE,
                    // which keeps them frozen for the whole write.
                    if (vox_hit || (d_q == '1)) begin
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                        addr_q  <= cell_addr;
                        ram_d_q <= vox_hit ? hit_color : BG_COLOR;
                    end else begin
                        d_q <= d_q + GRID_BITS'(1);
                    end
                end
                WRITE: begin
                    if (write_done) begin
                        we_q <= 1'b0;
                        d_q  <= '0;
                        if (u_q == '1) begin
                            u_q <= '0;
                            if (v_q == '1) begin
                                state_q <= DONE;
                                done    <= 1'b1;
                            end else begin
                                v_q     <= v_q + GRID_BITS'(1);
                                state_q <= SCAN;
                            end
                        end else begin
                            u_q     <= u_q + GRID_BITS'(1);
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb.we     = we_q;
    assign fb.addr   = addr_q;
    assign fb.ram_d  = ram_d_q;
    assign dbg_state = state_q;
endmodule
